// File: rtl/riscv_pkg.sv
// riscv_pkg: shared core widths and register-file constants
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] REG_X0 = 5'd0;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: load-pending bits (set by pend_set_i/pend_rd_i, cleared by WB we_i/rd_i), busy for rs1/rs2, pending count, sticky double-set error
module regfile_scoreboard
  import riscv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1_addr_i,
  input  logic [REG_AW-1:0] rs2_addr_i,
  input  logic              we_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic              pend_set_i,
  input  logic [REG_AW-1:0] pend_rd_i,
  output logic              rs1_busy_o,
  output logic              rs2_busy_o,
  output logic [REG_AW:0]   pend_cnt_o,
  output logic              pend_err_o
);
  logic [NREG-1:0] pend_q, pend_d, clr_m, set_m;
  logic [REG_AW:0] cnt_q, cnt_d;
  logic err_q, err_d, set_v, inc, dec;
  always_comb begin
    set_v = pend_set_i && pend_rd_i != REG_X0;
    clr_m = we_i ? NREG'(1) << rd_i : '0;
    set_m = set_v ? NREG'(1) << pend_rd_i : '0;
    pend_d = (pend_q & ~clr_m) | set_m;
    inc = set_v && !pend_q[pend_rd_i];
    dec = we_i && pend_q[rd_i] && !(set_v && pend_rd_i == rd_i);
    cnt_d = cnt_q + (REG_AW+1)'(inc) - (REG_AW+1)'(dec);
    err_d = err_q || (set_v && pend_q[pend_rd_i] && !(we_i && rd_i == pend_rd_i));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign rs1_busy_o = pend_q[rs1_addr_i] && !(we_i && rd_i == rs1_addr_i);
  assign rs2_busy_o = pend_q[rs2_addr_i] && !(we_i && rd_i == rs2_addr_i);
  assign pend_cnt_o = cnt_q;
  assign pend_err_o = err_q;
endmodule

// File: rtl/regfile_wb.sv
// regfile_wb: x0..x31 register file with WB write port, two bypassed ID read ports and load scoreboard (busy, count, error)
module regfile_wb
  import riscv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1_addr_id_i,
  input  logic [REG_AW-1:0] rs2_addr_id_i,
  output logic [XLEN-1:0]   rs1_data_id_o,
  output logic [XLEN-1:0]   rs2_data_id_o,
  input  logic              RegWrite_wb_i,
  input  logic [REG_AW-1:0] rd_wb_i,
  input  logic [XLEN-1:0]   Wr_reg_data_wb_i,
  input  logic              pend_set_i,
  input  logic [REG_AW-1:0] pend_rd_i,
  output logic              rs1_busy_o,
  output logic              rs2_busy_o,
  output logic [REG_AW:0]   pend_cnt_o,
  output logic              pend_err_o
);
  logic [XLEN-1:0] regs_q [NREG];
  logic wr_v;
  always_comb begin
    wr_v = RegWrite_wb_i && rd_wb_i != REG_X0;
    rs1_data_id_o = rs1_addr_id_i == REG_X0 ? '0 :
                    wr_v && rd_wb_i == rs1_addr_id_i ? Wr_reg_data_wb_i : regs_q[rs1_addr_id_i];
    rs2_data_id_o = rs2_addr_id_i == REG_X0 ? '0 :
                    wr_v && rd_wb_i == rs2_addr_id_i ? Wr_reg_data_wb_i : regs_q[rs2_addr_id_i];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wr_v) begin
      regs_q[rd_wb_i] <= Wr_reg_data_wb_i;
    end
  end
  regfile_scoreboard u_sb (
    .clk(clk),
    .rst(rst),
    .rs1_addr_i(rs1_addr_id_i),
    .rs2_addr_i(rs2_addr_id_i),
    .we_i(RegWrite_wb_i),
    .rd_i(rd_wb_i),
    .pend_set_i(pend_set_i),
    .pend_rd_i(pend_rd_i),
    .rs1_busy_o(rs1_busy_o),
    .rs2_busy_o(rs2_busy_o),
    .pend_cnt_o(pend_cnt_o),
    .pend_err_o(pend_err_o)
  );
endmodule

// File: tb/tb_regfile_wb.sv
// tb_regfile_wb: randomized and directed scoreboard bench for regfile_wb against an array-based reference model
module tb_regfile_wb;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] rs1_a = '0, rs2_a = '0, rd = '0, prd = '0;
  logic [31:0] rs1_d, rs2_d, wd = '0;
  logic we = 1'b0, ps = 1'b0, b1, b2, err;
  logic [5:0] cnt;
  typedef struct {
    logic [31:0] d1;
    logic [31:0] d2;
    logic b1;
    logic b2;
    logic [5:0] cnt;
    logic err;
  } exp_t;
  exp_t q[$];
  logic [31:0] m_reg [32];
  bit m_pend [32];
  bit m_err;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  regfile_wb dut (
    .clk(clk),
    .rst(rst),
    .rs1_addr_id_i(rs1_a),
    .rs2_addr_id_i(rs2_a),
    .rs1_data_id_o(rs1_d),
    .rs2_data_id_o(rs2_d),
    .RegWrite_wb_i(we),
    .rd_wb_i(rd),
    .Wr_reg_data_wb_i(wd),
    .pend_set_i(ps),
    .pend_rd_i(prd),
    .rs1_busy_o(b1),
    .rs2_busy_o(b2),
    .pend_cnt_o(cnt),
    .pend_err_o(err)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("rs1_data", rs1_d, e.d1);
      chk("rs2_data", rs2_d, e.d2);
      chk("rs1_busy", 32'(b1), 32'(e.b1));
      chk("rs2_busy", 32'(b2), 32'(e.b2));
      chk("pend_cnt", 32'(cnt), 32'(e.cnt));
      chk("pend_err", 32'(err), 32'(e.err));
    end
  end
  function automatic logic [31:0] rd_model(input logic [4:0] a);
    if (a == 0) return '0;
    if (we && rd == a) return wd;
    return m_reg[a];
  endfunction
  function automatic logic busy_model(input logic [4:0] a);
    return a != 0 && m_pend[a] && !(we && rd == a);
  endfunction
  function automatic logic [5:0] popcount();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_pend[i]);
    return 6'(c);
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_reg[i] = '0;
      m_pend[i] = 0;
    end
    m_err = 0;
  endtask
  task automatic cyc(input bit r, input logic [4:0] a1, input logic [4:0] a2, input bit w,
                     input logic [4:0] d, input logic [31:0] v, input bit s, input logic [4:0] p);
    exp_t e;
    rst = r; rs1_a = a1; rs2_a = a2; we = w; rd = d; wd = v; ps = s; prd = p;
    e.d1 = rd_model(a1);
    e.d2 = rd_model(a2);
    e.b1 = busy_model(a1);
    e.b2 = busy_model(a2);
    e.cnt = popcount();
    e.err = m_err;
    q.push_back(e);
    if (r) model_reset();
    else begin
      if (w && d != 0) m_reg[d] = v;
      if (s && p != 0 && m_pend[p] && !(w && d == p)) m_err = 1;
      if (w) m_pend[d] = 0;
      if (s && p != 0) m_pend[p] = 1;
    end
    @(posedge clk);
    #1;
  endtask
  function automatic logic [4:0] ra();
    return $urandom_range(0, 3) == 0 ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
  endfunction
  initial begin
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    for (int i = 0; i < 32; i++) cyc(0, 5'(i), 5'(31 - i), 0, 0, 0, 0, 0);
    cyc(0, 5, 0, 1, 5, 32'hDEADBEEF, 0, 0);
    cyc(0, 5, 0, 0, 0, 0, 0, 0);
    cyc(0, 5, 0, 1, 0, 32'h12345678, 0, 0);
    cyc(0, 5, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 7);
    cyc(0, 0, 0, 0, 0, 0, 1, 9);
    cyc(0, 7, 9, 0, 0, 0, 0, 0);
    cyc(0, 7, 9, 1, 7, 32'h00000077, 0, 0);
    cyc(0, 7, 9, 0, 0, 0, 0, 0);
    cyc(0, 9, 7, 1, 9, 32'h00000099, 1, 9);
    cyc(0, 9, 7, 0, 0, 0, 1, 0);
    cyc(0, 3, 9, 0, 0, 0, 1, 3);
    cyc(0, 3, 9, 0, 0, 0, 1, 3);
    cyc(0, 3, 9, 0, 0, 0, 0, 0);
    cyc(1, 3, 5, 1, 4, 32'hCAFEF00D, 1, 6);
    cyc(0, 3, 5, 0, 0, 0, 0, 0);
    cyc(0, 4, 6, 0, 0, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      bit r, w, s;
      r = $urandom_range(0, 99) == 0;
      w = !r && $urandom_range(0, 1) == 1;
      s = !r && $urandom_range(0, 3) == 0;
      cyc(r, ra(), ra(), w, ra(), $urandom, s, ra());
    end
    for (int t = 0; t < 10 && q.size() > 0; t++) @(posedge clk);
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
